systolic_matmul_nxn: RTL and testbench

Parametrised N×N output-stationary systolic matrix multiplier, the successor of the fixed 4×4 array. It accepts A and B one inner-product index per beat through a valid/ready stream and performs the input skewing internally. It computes C = A·B (or C += A·B in accumulate mode) and drains C row by row through a second valid/ready stream. It sits between the UART frame unpacker and the result serializer.

---
 rtl/systolic_pkg.sv | 26 ++
 rtl/systolic_pe_p.sv | 44 ++++
 rtl/systolic_matmul_nxn.sv | 178 +++++++++++++++++
 tb/tb_systolic_matmul_nxn.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the N x N output-stationary systolic multiplier.
package systolic_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      FLUSH = 2'd2,
      DRAIN = 2'd3
   } state_t;

   localparam int unsigned N_DEFAULT = 4;

   // Cycles needed after the last beat for it to reach PE(N-1,N-1) and be accumulated.
   function automatic int unsigned flush_len(input int unsigned n);
      return 2 * n - 1;
   endfunction

   // Counter width able to index 0..n-1; never narrower than one bit.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   localparam int unsigned FLUSH_LEN_DEFAULT = flush_len(N_DEFAULT);
   localparam int unsigned CNT_W_DEFAULT     = cnt_w(N_DEFAULT);

endpackage

// File: rtl/systolic_pe_p.sv
// Processing element: forwards a east and b south one cycle later and accumulates a*b.
module systolic_pe_p
   import systolic_pkg::*;
#(
   parameter int DW    = 16,
   parameter int ACC_W = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    en,
   input  logic signed [DW-1:0]    a_in,
   input  logic signed [DW-1:0]    b_in,
   output logic signed [DW-1:0]    a_out,
   output logic signed [DW-1:0]    b_out,
   output logic signed [ACC_W-1:0] acc
);

   logic signed [2*DW-1:0]  w_prod;
   logic signed [ACC_W-1:0] w_prod_ext;

   assign w_prod     = a_in * b_in;
   assign w_prod_ext = ACC_W'(w_prod);

   // Accumulator wraps modulo 2^ACC_W; operand registers only move while the array is enabled.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc   <= '0;
         a_out <= '0;
         b_out <= '0;
      end else begin
         if (clr) begin
            acc <= '0;
         end else if (en) begin
            acc <= acc + w_prod_ext;
         end
         if (en) begin
            a_out <= a_in;
            b_out <= b_in;
         end
      end
   end

endmodule

// File: rtl/systolic_matmul_nxn.sv
// N x N output-stationary systolic multiplier: skews A/B beats internally, drains C row by row.
//
// state | meaning
// IDLE  | waiting for start; accumulators hold the last C
// LOAD  | accepting N beats (in_ready high); r_cnt counts beats left down to 0
// FLUSH | zeros pushed in for 2N-1 cycles so the last beat reaches every PE
// DRAIN | presenting C[r_row][*] until each row is accepted
module systolic_matmul_nxn
   import systolic_pkg::*;
#(
   parameter int N     = 4,
   parameter int DW    = 16,
   parameter int ACC_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               acc_mode,
   output logic               busy,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [N*DW-1:0]    a_col,
   input  logic [N*DW-1:0]    b_row,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [N*ACC_W-1:0] out_row,
   output logic               out_last
);

   localparam int unsigned FLUSH_CYC = flush_len(N);
   localparam int unsigned TW        = cnt_w(2 * N);
   localparam int unsigned RW        = cnt_w(N);
   localparam logic [TW-1:0] BEAT_LOAD  = TW'(N - 1);
   localparam logic [TW-1:0] FLUSH_LOAD = TW'(FLUSH_CYC - 1);
   localparam logic [TW-1:0] T_ONE      = TW'(1);
   localparam logic [RW-1:0] ROW_LAST   = RW'(N - 1);
   localparam logic [RW-1:0] R_ONE      = RW'(1);

   state_t        r_state;
   logic [TW-1:0] r_cnt;
   logic [RW-1:0] r_row;

   logic w_hs;
   logic w_en;
   logic w_clr;

   logic [DW-1:0]    w_a_pe    [N];
   logic [DW-1:0]    w_b_pe    [N];
   logic [DW-1:0]    w_a_in    [N][N];
   logic [DW-1:0]    w_b_in    [N][N];
   logic [DW-1:0]    w_a_east  [N][N];
   logic [DW-1:0]    w_b_south [N][N];
   logic [ACC_W-1:0] w_acc     [N][N];

   assign in_ready  = (r_state == LOAD);
   assign busy      = (r_state != IDLE);
   assign out_valid = (r_state == DRAIN);
   assign out_last  = out_valid && (r_row == ROW_LAST);
   assign w_hs      = in_ready && in_valid;
   assign w_en      = (r_state == LOAD) || (r_state == FLUSH);
   assign w_clr     = (r_state == IDLE) && start && !acc_mode;

   // Sequencing controller; beat and flush timers share one down-counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_row   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state <= LOAD;
                  r_cnt   <= BEAT_LOAD;
               end
            end
            LOAD: begin
               if (w_hs) begin
                  if (r_cnt == '0) begin
                     r_state <= FLUSH;
                     r_cnt   <= FLUSH_LOAD;
                  end else begin
                     r_cnt <= r_cnt - T_ONE;
                  end
               end
            end
            FLUSH: begin
               if (r_cnt == '0) begin
                  r_state <= DRAIN;
                  r_row   <= '0;
               end else begin
                  r_cnt <= r_cnt - T_ONE;
               end
            end
            DRAIN: begin
               if (out_ready) begin
                  if (r_row == ROW_LAST) begin
                     r_state <= IDLE;
                  end else begin
                     r_row <= r_row + R_ONE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Skew lines: slice i is delayed by i stages; non-handshake cycles inject zero bubbles.
   for (genvar i = 0; i < N; i++) begin : g_skew
      logic [DW-1:0] w_a_head;
      logic [DW-1:0] w_b_head;
      assign w_a_head = w_hs ? a_col[i*DW +: DW] : '0;
      assign w_b_head = w_hs ? b_row[i*DW +: DW] : '0;
      if (i == 0) begin : g_direct
         assign w_a_pe[i] = w_a_head;
         assign w_b_pe[i] = w_b_head;
      end else begin : g_dly
         logic [DW-1:0] r_a_sk [i];
         logic [DW-1:0] r_b_sk [i];
         // Shift register advancing with the array.
         always_ff @(posedge clk) begin
            if (rst) begin
               for (int s = 0; s < i; s++) begin
                  r_a_sk[s] <= '0;
                  r_b_sk[s] <= '0;
               end
            end else if (w_en) begin
               r_a_sk[0] <= w_a_head;
               r_b_sk[0] <= w_b_head;
               for (int s = 1; s < i; s++) begin
                  r_a_sk[s] <= r_a_sk[s-1];
                  r_b_sk[s] <= r_b_sk[s-1];
               end
            end
         end
         assign w_a_pe[i] = r_a_sk[i-1];
         assign w_b_pe[i] = r_b_sk[i-1];
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_row
      for (genvar j = 0; j < N; j++) begin : g_col
         if (j == 0) begin : g_a_edge
            assign w_a_in[i][j] = w_a_pe[i];
         end else begin : g_a_int
            assign w_a_in[i][j] = w_a_east[i][j-1];
         end
         if (i == 0) begin : g_b_edge
            assign w_b_in[i][j] = w_b_pe[j];
         end else begin : g_b_int
            assign w_b_in[i][j] = w_b_south[i-1][j];
         end
         systolic_pe_p #(.DW(DW), .ACC_W(ACC_W)) u_pe (
            .clk   (clk),
            .rst   (rst),
            .clr   (w_clr),
            .en    (w_en),
            .a_in  (w_a_in[i][j]),
            .b_in  (w_b_in[i][j]),
            .a_out (w_a_east[i][j]),
            .b_out (w_b_south[i][j]),
            .acc   (w_acc[i][j])
         );
      end
   end

   // Row mux; forced to zero outside DRAIN so idle outputs are quiet.
   always_comb begin
      out_row = '0;
      if (out_valid) begin
         for (int j = 0; j < N; j++) begin
            out_row[j*ACC_W +: ACC_W] = w_acc[r_row][j];
         end
      end
   end

endmodule

// File: tb/tb_systolic_matmul_nxn.sv
module tb_systolic_matmul_nxn;
   localparam int N  = 4;
   localparam int DW = 16;
   localparam int AW = 32;
   localparam int RWD = N * AW;

   logic           clk = 1'b0;
   logic           rst, start, acc_mode, busy, in_valid, in_ready;
   logic [N*DW-1:0] a_col, b_row;
   logic           out_valid, out_ready, out_last;
   logic [RWD-1:0] out_row;

   always #5 clk = ~clk;

   systolic_matmul_nxn #(.N(N), .DW(DW), .ACC_W(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .acc_mode(acc_mode), .busy(busy),
      .in_valid(in_valid), .in_ready(in_ready), .a_col(a_col), .b_row(b_row),
      .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_last(out_last)
   );

   int vectors = 0;
   int miscompares = 0;

   shortint     ma [N][N];
   shortint     mb [N][N];
   logic [31:0] cm [N][N];

   logic [RWD-1:0] exp_q  [$];
   bit             last_q [$];

   int ready_mode = 0;
   int stall_cnt  = 0;
   int rows_seen  = 0;

   task automatic check(input string nm, input logic [RWD-1:0] act, input logic [RWD-1:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
      end
   endtask

   task automatic cm_clear();
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            cm[i][j] = '0;
   endtask

   // Reference: plain matrix product with 32-bit wrap, then queue the expected rows.
   task automatic model_job(input bit acc);
      logic [RWD-1:0] row;
      if (!acc) cm_clear();
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            for (int k = 0; k < N; k++)
               cm[i][j] = cm[i][j] + 32'(int'(ma[i][k]) * int'(mb[k][j]));
      for (int r = 0; r < N; r++) begin
         for (int j = 0; j < N; j++) row[j*AW +: AW] = cm[r][j];
         exp_q.push_back(row);
         last_q.push_back(r == N - 1);
      end
   endtask

   // Output consumer: always ready, random, or a 3-cycle stall on row 1.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (ready_mode == 2 && out_valid && (rows_seen % N) == 1 && stall_cnt < 3) begin
            out_ready = 1'b0;
            stall_cnt++;
         end else if (ready_mode == 1) begin
            out_ready = 1'($urandom_range(0, 1));
         end else begin
            out_ready = 1'b1;
         end
      end
   end

   // Monitor: pops expected rows on handshakes and checks stability while stalled.
   initial begin
      bit             hold = 0;
      logic [RWD-1:0] held_row;
      logic           held_last;
      logic [RWD-1:0] er;
      bit             el;
      forever begin
         @(negedge clk);
         if (hold && !rst) begin
            check("hold_valid", RWD'(out_valid), RWD'(1));
            check("hold_row", out_row, held_row);
            check("hold_last", RWD'(out_last), RWD'(held_last));
         end
         hold      = out_valid && !out_ready && !rst;
         held_row  = out_row;
         held_last = out_last;
         if (out_valid && out_ready && !rst) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_row: got %h expected none", out_row);
            end else begin
               er = exp_q.pop_front();
               el = last_q.pop_front();
               check("row", out_row, er);
               check("out_last", RWD'(out_last), RWD'(el));
            end
            rows_seen++;
         end
      end
   end

   // One job; entered and left at posedge+1.
   // gaps: 0 none, 1 alternate, 2 random. abort3: reset after three beats.
   task automatic run_job(input bit acc, input int gaps, input int rmode, input bit abort3);
      int k = 0, guard = 0, phase = 0, lat;
      bit v, hs;
      ready_mode = rmode;
      stall_cnt  = 0;
      start      = 1'b1;
      acc_mode   = acc;
      @(negedge clk);
      check("idle_busy", RWD'(busy), RWD'(0));
      check("idle_out_valid", RWD'(out_valid), RWD'(0));
      @(posedge clk); #1;
      start    = 1'b0;
      acc_mode = 1'($urandom_range(0, 1));
      while (k < N && guard < 200) begin
         v = (gaps == 0) ? 1'b1 : (gaps == 1) ? (phase % 2 == 0) : 1'($urandom_range(0, 1));
         in_valid = v;
         for (int i = 0; i < N; i++) begin
            a_col[i*DW +: DW] = v ? ma[i][k] : DW'($urandom);
            b_row[i*DW +: DW] = v ? mb[k][i] : DW'($urandom);
         end
         @(negedge clk);
         if (phase == 0) check("in_ready_t1", RWD'(in_ready), RWD'(1));
         hs = in_valid && in_ready;
         @(posedge clk); #1;
         if (hs) k++;
         phase++;
         guard++;
         if (abort3 && k == 3) begin
            rst = 1'b1;
            in_valid = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            in_valid = 1'b0;
            @(negedge clk);
            check("abort_busy", RWD'(busy), RWD'(0));
            check("abort_in_ready", RWD'(in_ready), RWD'(0));
            check("abort_out_valid", RWD'(out_valid), RWD'(0));
            cm_clear();
            @(posedge clk); #1;
            return;
         end
      end
      in_valid = 1'b0;
      if (k < N) begin
         vectors++;
         miscompares++;
         $display("FAIL beat_timeout: got %0d beats expected %0d", k, N);
      end
      model_job(acc);
      if (gaps == 0) begin
         lat = 1;
         forever begin
            @(negedge clk);
            if (out_valid || lat > 100) break;
            @(posedge clk);
            lat++;
         end
         check("latency", RWD'(lat), RWD'(2 * N));
      end
      guard = 0;
      while (exp_q.size() > 0 && guard < 400) begin
         @(negedge clk); #1;
         guard++;
      end
      if (exp_q.size() > 0) begin
         vectors++;
         miscompares++;
         $display("FAIL drain_timeout: got %0d rows pending expected 0", exp_q.size());
         exp_q.delete();
         last_q.delete();
      end
      @(posedge clk); #1;
   endtask

   task automatic fill(input int kind);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            case (kind)
               0: begin ma[i][j] = (i == j) ? 16'sd1 : 16'sd0; mb[i][j] = shortint'(4 * i + j + 1); end
               1: begin ma[i][j] = 16'sd1;  mb[i][j] = 16'sd1; end
               2: begin ma[i][j] = -16'sd1; mb[i][j] = 16'sd2; end
               3: begin ma[i][j] = 16'sh7FFF; mb[i][j] = 16'sh7FFF; end
               4: begin ma[i][j] = (i == j) ? 16'sd1 : 16'sd0; mb[i][j] = (i == j) ? 16'sd1 : 16'sd0; end
               default: begin ma[i][j] = shortint'($urandom); mb[i][j] = shortint'($urandom); end
            endcase
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; acc_mode = 1'b0; in_valid = 1'b0;
      a_col = '0; b_row = '0;
      cm_clear();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", RWD'(busy), RWD'(0));
      check("rst_in_ready", RWD'(in_ready), RWD'(0));
      check("rst_out_valid", RWD'(out_valid), RWD'(0));
      check("rst_out_last", RWD'(out_last), RWD'(0));
      check("rst_out_row", out_row, '0);
      @(posedge clk); #1;
      rst = 1'b0;

      fill(0); run_job(0, 0, 0, 0);
      fill(1); run_job(0, 0, 0, 0);
      run_job(1, 0, 0, 0);
      fill(2); run_job(0, 0, 0, 0);
      fill(0); run_job(0, 1, 2, 0);
      fill(3); run_job(0, 0, 0, 0);
      fill(1); run_job(1, 0, 0, 1);
      fill(4); run_job(1, 0, 0, 0);
      for (int t = 0; t < 12; t++) begin
         fill(9);
         run_job(1'($urandom_range(0, 1)), 2, 1, 0);
      end
      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
